// File: rtl/gate_sensor_decoder.sv
// gate_sensor_decoder: two-beam car-park gate decoder.
// Each beam is synchronised, debounced, then a passage FSM classifies the
// filtered (a,b) sequence into entries, exits and faults.
// Optional passage timeout is compiled in when GATE_TIMEOUT_EN is defined.
module gate_sensor_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic car_enter,
    output logic car_exit,
    output logic busy,
    output logic fault
);

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_AB,
        IN_B,
        OUT_B,
        OUT_AB,
        OUT_A,
        WAIT_CLR
    } state_e;

    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // Bit 1 carries sensor_a, bit 0 carries sensor_b throughout.
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] filt_ab;
    logic [1:0] flip_ab;

    state_e state_q, state_d;
    logic   enter_q, enter_d;
    logic   exit_q, exit_d;
    logic   fault_q, fault_d;

    // Two-flop synchronisers for both asynchronous beams.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {sensor_a, sensor_b};
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_deb
        logic [15:0] cnt_q, cnt_d;
        logic        filt_q, filt_d;

        // Count consecutive disagreeing cycles; accept the new level on the last one.
        always_comb begin
            cnt_d  = '0;
            filt_d = filt_q;
            if (sync2_q[g] != filt_q) begin
                if (cnt_q == DEB_LAST) begin
                    filt_d = sync2_q[g];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        end

        // Debounce counter and filtered level registers.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                filt_q <= filt_d;
            end
        end

        assign filt_ab[g] = filt_q;
        assign flip_ab[g] = (filt_d != filt_q);
    end

`ifdef GATE_TIMEOUT_EN
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

    logic        active;
    logic [23:0] tmo_q, tmo_d;

    assign active = (state_q != IDLE) && (state_q != WAIT_CLR);

    // Quiet-time counter: restarts on any filtered change or outside a passage.
    always_comb begin
        tmo_d = tmo_q + 24'd1;
        if (!active || (|flip_ab)) begin
            tmo_d = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    // Timeout not built: keep the parameter and change flags referenced.
    logic [24:0] unused_cfg;
    assign unused_cfg = {24'(TIMEOUT_CYCLES), ^flip_ab};
`endif

    // Passage FSM next-state and registered-pulse decode.
    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        fault_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                case (filt_ab)
                    2'b10:   state_d = IN_A;
                    2'b01:   state_d = OUT_B;
                    2'b11: begin
                        state_d = WAIT_CLR;
                        fault_d = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
            IN_A: begin
                case (filt_ab)
                    2'b10:   state_d = IN_A;
                    2'b11:   state_d = IN_AB;
                    2'b00:   state_d = IDLE;
                    default: begin
                        state_d = WAIT_CLR;
                        fault_d = 1'b1;
                    end
                endcase
            end
            IN_AB: begin
                case (filt_ab)
                    2'b11:   state_d = IN_AB;
                    2'b01:   state_d = IN_B;
                    2'b10:   state_d = IN_A;
                    default: begin
                        state_d = WAIT_CLR;
                        fault_d = 1'b1;
                    end
                endcase
            end
            IN_B: begin
                case (filt_ab)
                    2'b01:   state_d = IN_B;
                    2'b00: begin
                        state_d = IDLE;
                        enter_d = 1'b1;
                    end
                    2'b11:   state_d = IN_AB;
                    default: begin
                        state_d = WAIT_CLR;
                        fault_d = 1'b1;
                    end
                endcase
            end
            OUT_B: begin
                case (filt_ab)
                    2'b01:   state_d = OUT_B;
                    2'b11:   state_d = OUT_AB;
                    2'b00:   state_d = IDLE;
                    default: begin
                        state_d = WAIT_CLR;
                        fault_d = 1'b1;
                    end
                endcase
            end
            OUT_AB: begin
                case (filt_ab)
                    2'b11:   state_d = OUT_AB;
                    2'b10:   state_d = OUT_A;
                    2'b01:   state_d = OUT_B;
                    default: begin
                        state_d = WAIT_CLR;
                        fault_d = 1'b1;
                    end
                endcase
            end
            OUT_A: begin
                case (filt_ab)
                    2'b10:   state_d = OUT_A;
                    2'b00: begin
                        state_d = IDLE;
                        exit_d  = 1'b1;
                    end
                    2'b11:   state_d = OUT_AB;
                    default: begin
                        state_d = WAIT_CLR;
                        fault_d = 1'b1;
                    end
                endcase
            end
            WAIT_CLR: begin
                if (filt_ab == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef GATE_TIMEOUT_EN
        // Timeout only fires while the passage is parked in one state.
        if (active && (state_d == state_q) && (tmo_q == TMO_LAST)) begin
            state_d = WAIT_CLR;
            fault_d = 1'b1;
        end
`endif
    end

    // State register and registered event pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            fault_q <= fault_d;
        end
    end

    assign car_enter = enter_q;
    assign car_exit  = exit_q;
    assign fault     = fault_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Bench for gate_sensor_decoder (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64).
// Behavioural model: beams tracked as sample histories, a passage as a
// direction plus a position on a 0..4 ladder of beam patterns.
module tb_gate_sensor_decoder;

    localparam int D = 4;
    localparam int T = 64;

    logic clock    = 1'b0;
    logic reset_n  = 1'b0;
    logic sensor_a = 1'b0;
    logic sensor_b = 1'b0;
    logic car_enter, car_exit, busy, fault;

    gate_sensor_decoder #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .sensor_a (sensor_a),
        .sensor_b (sensor_b),
        .car_enter(car_enter),
        .car_exit (car_exit),
        .busy     (busy),
        .fault    (fault)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // model state
    bit [7:0] ha = '0, hb = '0;
    bit fa = 1'b0, fb = 1'b0;
    int dir = 0;     // 0 idle, 1 entry, 2 exit, 3 waiting for clear
    int pos = 0;
    int quiet = 0;
    bit e_enter, e_exit, e_fault;

    // observed values from the last tick
    bit s_enter, s_exit, s_fault, s_busy;
    int n_enter = 0, n_exit = 0, n_fault = 0;

    typedef struct {
        int       n;
        bit [1:0] st [6];
        int       en;
        int       ex;
        int       fl;
        bit       bz;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Position of a beam pattern on the ladder of a given direction.
    function automatic int ladder(input int d, input bit a, input bit b);
        if (!a && !b) return 0;
        if (a && b)   return 2;
        if (d == 1)   return a ? 1 : 3;
        return b ? 1 : 3;
    endfunction

    task automatic model_step();
        bit old_active;
        bit fl_a, fl_b;
        int p;
        e_enter = 0; e_exit = 0; e_fault = 0;
        if (!reset_n) begin
            ha = '0; hb = '0; fa = 0; fb = 0; dir = 0; pos = 0; quiet = 0;
            return;
        end
        old_active = (dir == 1) || (dir == 2);
        case (dir)
            0: begin
                if (fa && fb) begin dir = 3; e_fault = 1; end
                else if (fa) begin dir = 1; pos = 1; end
                else if (fb) begin dir = 2; pos = 1; end
            end
            3: if (!fa && !fb) dir = 0;
            default: begin
                p = ladder(dir, fa, fb);
                if (pos == 3 && p == 0) p = 4;
                if (p == pos) begin
`ifdef GATE_TIMEOUT_EN
                    if (quiet == T - 1) begin dir = 3; e_fault = 1; end
`endif
                end else if (p == pos + 1 || p == pos - 1) begin
                    pos = p;
                    if (p == 0) dir = 0;
                    else if (p == 4) begin
                        if (dir == 1) e_enter = 1; else e_exit = 1;
                        dir = 0;
                    end
                end else begin
                    dir = 3; e_fault = 1;
                end
            end
        endcase
        ha = {ha[6:0], sensor_a};
        hb = {hb[6:0], sensor_b};
        fl_a = (ha[D+1:2] == {D{~fa}});
        fl_b = (hb[D+1:2] == {D{~fb}});
        if (fl_a) fa = ~fa;
        if (fl_b) fb = ~fb;
        if (fl_a || fl_b || !old_active) quiet = 0; else quiet++;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        chk("car_enter", int'(car_enter), int'(e_enter));
        chk("car_exit",  int'(car_exit),  int'(e_exit));
        chk("fault",     int'(fault),     int'(e_fault));
        chk("busy",      int'(busy),      int'(dir != 0));
        s_enter = car_enter; s_exit = car_exit; s_fault = fault; s_busy = busy;
        n_enter += int'(car_enter);
        n_exit  += int'(car_exit);
        n_fault += int'(fault);
        @(negedge clock);
    endtask

    task automatic hold(input bit a, input bit b, input int n);
        sensor_a = a;
        sensor_b = b;
        repeat (n) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b_en, b_ex, b_fl, at, hits, first_busy, first_fault, seen;
        bit [1:0] cur, nxt;

        tbl[0] = '{4, '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00}, 1, 0, 0, 1'b0};
        tbl[1] = '{4, '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00}, 0, 1, 0, 1'b0};
        tbl[2] = '{2, '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, 0, 0, 0, 1'b0};
        tbl[3] = '{2, '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, 0, 0, 0, 1'b0};
        tbl[4] = '{2, '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, 0, 0, 1, 1'b0};
        tbl[5] = '{6, '{2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00}, 1, 0, 0, 1'b0};
        tbl[6] = '{3, '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00}, 0, 0, 1, 1'b0};
        tbl[7] = '{2, '{2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00}, 0, 0, 1, 1'b1};
        tbl[8] = '{6, '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11}, 1, 0, 0, 1'b1};
        tbl[9] = '{6, '{2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00}, 0, 1, 0, 1'b0};

        // reset
        repeat (3) tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_fault", int'(fault), 0);
        reset_n = 1'b1;
        hold(0, 0, 10);
        chk("post_reset_busy", int'(s_busy), 0);

        // table vectors
        for (int i = 0; i < 10; i++) begin
            hold(0, 0, 20);
            b_en = n_enter; b_ex = n_exit; b_fl = n_fault;
            for (int s = 0; s < tbl[i].n; s++) begin
                cur = tbl[i].st[s];
                hold(cur[1], cur[0], 20);
            end
            chk($sformatf("vec%0d_enter", i), n_enter - b_en, tbl[i].en);
            chk($sformatf("vec%0d_exit", i),  n_exit - b_ex,  tbl[i].ex);
            chk($sformatf("vec%0d_fault", i), n_fault - b_fl, tbl[i].fl);
            chk($sformatf("vec%0d_busy", i),  int'(s_busy),   int'(tbl[i].bz));
        end

        // entry latency: car_enter 7 cycles after raw b falls
        hold(0, 0, 20);
        hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20);
        b_ex = n_exit;
        sensor_b = 1'b0;
        at = -1; hits = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (s_enter) begin hits++; at = k; end
        end
        chk("enter_latency", at, 7);
        chk("enter_pulses", hits, 1);
        chk("enter_no_exit", n_exit - b_ex, 0);

        // exit: busy from OUT_B entry until idle
        hold(0, 0, 20);
        hold(0, 1, 20);
        chk("exit_busy_outb", int'(s_busy), 1);
        b_ex = n_exit;
        hold(1, 1, 20); hold(1, 0, 20);
        chk("exit_busy_outa", int'(s_busy), 1);
        hold(0, 0, 20);
        chk("exit_pulses", n_exit - b_ex, 1);
        chk("exit_idle", int'(s_busy), 0);

        // debounce: 3-cycle glitch ignored, sustained level accepted
        hold(0, 0, 20);
        hold(1, 0, 3);
        sensor_a = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (s_busy) seen = 1;
        end
        chk("glitch_ignored", seen, 0);
        sensor_a = 1'b1;
        first_busy = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (s_busy && first_busy < 0) first_busy = k;
        end
        chk("debounce_latency", first_busy, 7);
        b_en = n_enter; b_ex = n_exit; b_fl = n_fault;
        hold(0, 0, 20);
        chk("backout_idle", int'(s_busy), 0);
        chk("backout_no_pulse", (n_enter - b_en) + (n_exit - b_ex) + (n_fault - b_fl), 0);

        // illegal simultaneous rise: one fault, held until both clear
        b_fl = n_fault;
        hold(1, 1, 20);
        chk("illegal_fault", n_fault - b_fl, 1);
        hold(0, 1, 20);
        chk("wait_clr_hold", int'(s_busy), 1);
        hold(0, 0, 20);
        chk("wait_clr_exit", int'(s_busy), 0);
        chk("illegal_single", n_fault - b_fl, 1);

        // reset mid-passage
        hold(1, 0, 20); hold(1, 1, 20);
        chk("in_ab_busy", int'(s_busy), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_busy",  int'(busy), 0);
        chk("rst_async_enter", int'(car_enter), 0);
        chk("rst_async_exit",  int'(car_exit), 0);
        chk("rst_async_fault", int'(fault), 0);
        sensor_a = 1'b0; sensor_b = 1'b0;
        @(negedge clock);
        repeat (3) tick();
        reset_n = 1'b1;
        b_en = n_enter; b_ex = n_exit; b_fl = n_fault;
        hold(0, 0, 20);
        chk("rst_release_idle", int'(s_busy), 0);
        chk("rst_no_pulse", (n_enter - b_en) + (n_exit - b_ex) + (n_fault - b_fl), 0);

        // timeout behaviour with a parked passage
        sensor_a = 1'b1;
        first_busy = -1; first_fault = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (s_busy && first_busy < 0) first_busy = k;
            if (s_fault && first_fault < 0) first_fault = k;
        end
`ifdef GATE_TIMEOUT_EN
        chk("timeout_gap", first_fault - first_busy, T);
        chk("timeout_wait_clr", int'(s_busy), 1);
`else
        chk("no_timeout_fault", first_fault, -1);
        chk("no_timeout_busy", int'(s_busy), 1);
`endif
        hold(0, 0, 20);
        chk("timeout_cleared", int'(s_busy), 0);

        // random walk, mostly single-beam steps, occasional long holds
        cur = 2'b00;
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 4) != 0)
                nxt = cur ^ (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
            else
                nxt = 2'($urandom_range(0, 3));
            cur = nxt;
            if (it == 300) begin
                reset_n = 1'b0;
                tick(); tick();
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 19) == 0)
                hold(cur[1], cur[0], $urandom_range(60, 90));
            else
                hold(cur[1], cur[0], $urandom_range(1, 10));
        end
        hold(0, 0, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
